// File: rtl/lc3b_types.sv
// Shared types for the LC-3b out-of-order core: ALU opcodes, ROB tags, CDB bus.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package lc3b_types;

    typedef logic [15:0] lc3b_word;
    typedef logic [2:0]  rob_tag;

    // Encodings 0..6 are defined; 3'd7 is left undefined and yields 0 in the ALU.
    typedef enum logic [2:0] {
        alu_add  = 3'd0,
        alu_and  = 3'd1,
        alu_not  = 3'd2,
        alu_pass = 3'd3,
        alu_sll  = 3'd4,
        alu_srl  = 3'd5,
        alu_sra  = 3'd6
    } lc3b_aluop;

    // Common data bus beat.
    typedef struct packed {
        logic     valid;
        rob_tag   tag;
        lc3b_word data;
    } CDB;

    // One reservation-station slot.
    typedef struct packed {
        logic      busy;
        lc3b_aluop op;
        rob_tag    dest;
        lc3b_word  vj;
        lc3b_word  vk;
        rob_tag    qj;
        rob_tag    qk;
        logic      rdy_j;
        logic      rdy_k;
    } rs_slot_t;

    // Width of a slot index; at least one bit so a single-entry station still has an index.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/reservation_station_alu.sv
// 16-bit LC-3b ALU: add/and/not/pass and shifts by b[3:0].
// Latency: purely combinational.
// Backpressure: none.
// Ports: aluop (operation), a/b (operands), f (result).
module alu
    import lc3b_types::*;
(
    input  lc3b_aluop aluop,
    input  lc3b_word  a,
    input  lc3b_word  b,
    output lc3b_word  f
);

    logic [3:0] shamt;

    assign shamt = b[3:0];

    always_comb begin
        f = '0;
        case (aluop)
            alu_add:  f = a + b;                         // wraps, carry discarded
            alu_and:  f = a & b;
            alu_not:  f = ~a;
            alu_pass: f = a;
            alu_sll:  f = a << shamt;
            alu_srl:  f = a >> shamt;
            alu_sra:  f = lc3b_word'($signed(a) >>> shamt);
            default:  f = '0;                            // undefined opcodes
        endcase
    end

endmodule

// File: rtl/reservation_station.sv
// Reservation station: holds issued ALU ops, snoops the CDB for missing operands, executes one ready op per cycle.
// Latency: ready issue in N -> dispatch N+1 -> RS_CDB_out.valid from N+2; CDB capture in M -> result earliest M+2.
// Backpressure: result buffer holds until flush; dispatch only when buffer empty or flushed in the same cycle; full stalls issue.
//
// Ports:
//   clk, reset              clock, async active-high reset
//   issue_*                 one operation written per cycle when issue_valid and !full
//   full                    every slot occupied (from registered busy bits)
//   CDB_in                  snooped result bus {valid, tag, data}
//   RS_CDB_out              result request to the CDB arbiter, straight from the buffer register
//   flush                   arbiter grant: the presented result is taken this cycle
module reservation_station
    import lc3b_types::*;
#(
    parameter int ENTRIES = 3
) (
    input  logic      clk,
    input  logic      reset,
    input  logic      issue_valid,
    input  lc3b_aluop issue_op,
    input  rob_tag    issue_dest,
    input  lc3b_word  issue_Vj,
    input  lc3b_word  issue_Vk,
    input  rob_tag    issue_Qj,
    input  rob_tag    issue_Qk,
    input  logic      issue_rdy_j,
    input  logic      issue_rdy_k,
    output logic      full,
    input  CDB        CDB_in,
    output CDB        RS_CDB_out,
    input  logic      flush
);

    localparam int IDX_W = idx_width(ENTRIES);

    rs_slot_t           slot_q [ENTRIES];
    CDB                 buf_q;

    logic [ENTRIES-1:0] busy_vec;
    logic [ENTRIES-1:0] ready_vec;
    logic               free_vld;
    logic [IDX_W-1:0]   free_idx;
    logic               ready_vld;
    logic [IDX_W-1:0]   ready_idx;
    logic               do_issue;
    logic               do_dispatch;
    rs_slot_t           iss_slot;
    rs_slot_t           disp_slot;
    lc3b_word           alu_f;

    // Slot status vectors.
    always_comb begin
        busy_vec  = '0;
        ready_vec = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            busy_vec[i]  = slot_q[i].busy;
            ready_vec[i] = slot_q[i].busy & slot_q[i].rdy_j & slot_q[i].rdy_k;
        end
    end

    // Lowest-index free and ready slot: scan downwards so the lowest match is written last.
    // Both use registered busy bits, so a slot freed by this cycle's dispatch is not reused until next cycle.
    always_comb begin
        free_vld  = 1'b0;
        free_idx  = '0;
        ready_vld = 1'b0;
        ready_idx = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (!busy_vec[i]) begin
                free_vld = 1'b1;
                free_idx = IDX_W'(i);
            end
            if (ready_vec[i]) begin
                ready_vld = 1'b1;
                ready_idx = IDX_W'(i);
            end
        end
    end

    assign full        = &busy_vec;
    assign do_issue    = issue_valid & free_vld;
    assign do_dispatch = ready_vld & (~buf_q.valid | flush);

    // New slot contents, including a same-cycle CDB bypass so a value broadcast during issue is not lost.
    always_comb begin
        iss_slot       = '0;
        iss_slot.busy  = 1'b1;
        iss_slot.op    = issue_op;
        iss_slot.dest  = issue_dest;
        iss_slot.vj    = issue_Vj;
        iss_slot.vk    = issue_Vk;
        iss_slot.qj    = issue_Qj;
        iss_slot.qk    = issue_Qk;
        iss_slot.rdy_j = issue_rdy_j;
        iss_slot.rdy_k = issue_rdy_k;
        if (!issue_rdy_j && CDB_in.valid && (CDB_in.tag == issue_Qj)) begin
            iss_slot.vj    = CDB_in.data;
            iss_slot.rdy_j = 1'b1;
        end
        if (!issue_rdy_k && CDB_in.valid && (CDB_in.tag == issue_Qk)) begin
            iss_slot.vk    = CDB_in.data;
            iss_slot.rdy_k = 1'b1;
        end
    end

    assign disp_slot = slot_q[ready_idx];

    alu u_alu (
        .aluop (disp_slot.op),
        .a     (disp_slot.vj),
        .b     (disp_slot.vk),
        .f     (alu_f)
    );

    // Slot state: snoop, dispatch release and issue write. The issue target is never busy,
    // so it never collides with a snoop or dispatch on the same slot.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                slot_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < ENTRIES; i++) begin
                if (slot_q[i].busy && !slot_q[i].rdy_j && CDB_in.valid &&
                    (CDB_in.tag == slot_q[i].qj)) begin
                    slot_q[i].vj    <= CDB_in.data;
                    slot_q[i].rdy_j <= 1'b1;
                end
                if (slot_q[i].busy && !slot_q[i].rdy_k && CDB_in.valid &&
                    (CDB_in.tag == slot_q[i].qk)) begin
                    slot_q[i].vk    <= CDB_in.data;
                    slot_q[i].rdy_k <= 1'b1;
                end
                if (do_dispatch && (ready_idx == IDX_W'(i))) begin
                    slot_q[i].busy <= 1'b0;
                end
                if (do_issue && (free_idx == IDX_W'(i))) begin
                    slot_q[i] <= iss_slot;
                end
            end
        end
    end

    // Result buffer: reload on dispatch (possibly in the same cycle as a flush), clear on flush alone.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            buf_q <= '0;
        end else if (do_dispatch) begin
            buf_q.valid <= 1'b1;
            buf_q.tag   <= disp_slot.dest;
            buf_q.data  <= alu_f;
        end else if (flush && buf_q.valid) begin
            buf_q <= '0;
        end
    end

    assign RS_CDB_out = buf_q;

endmodule

// File: tb/tb_reservation_station.sv
// Directed bench for reservation_station with an abstract slot/buffer model checked every cycle.
// Latency: n/a.
// Backpressure: flush driven directly by the stimulus.
module tb_reservation_station;
    import lc3b_types::*;

    localparam int N = 3;

    logic      clk = 1'b0;
    logic      reset = 1'b1;
    logic      issue_valid = 1'b0;
    lc3b_aluop issue_op = alu_add;
    rob_tag    issue_dest = '0;
    lc3b_word  issue_Vj = '0;
    lc3b_word  issue_Vk = '0;
    rob_tag    issue_Qj = '0;
    rob_tag    issue_Qk = '0;
    logic      issue_rdy_j = 1'b0;
    logic      issue_rdy_k = 1'b0;
    logic      full;
    CDB        CDB_in = '0;
    CDB        RS_CDB_out;
    logic      flush = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    reservation_station #(.ENTRIES(N)) dut (
        .clk         (clk),
        .reset       (reset),
        .issue_valid (issue_valid),
        .issue_op    (issue_op),
        .issue_dest  (issue_dest),
        .issue_Vj    (issue_Vj),
        .issue_Vk    (issue_Vk),
        .issue_Qj    (issue_Qj),
        .issue_Qk    (issue_Qk),
        .issue_rdy_j (issue_rdy_j),
        .issue_rdy_k (issue_rdy_k),
        .full        (full),
        .CDB_in      (CDB_in),
        .RS_CDB_out  (RS_CDB_out),
        .flush       (flush)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    bit       m_busy [N];
    int       m_op   [N];
    rob_tag   m_dest [N];
    lc3b_word m_vj   [N];
    lc3b_word m_vk   [N];
    rob_tag   m_qj   [N];
    rob_tag   m_qk   [N];
    bit       m_rj   [N];
    bit       m_rk   [N];
    CDB       m_out = '0;

    function automatic int model_alu(input int op, input int a, input int b);
        int sh;
        int p;
        sh = b % 16;
        p  = 1 << sh;
        case (op)
            0: return (a + b) % 65536;
            1: return a & b;
            2: return 65535 - a;
            3: return a;
            4: return (a * p) % 65536;
            5: return a / p;
            6: return a / p + ((a >= 32768) ? (65536 - 65536 / p) : 0);
            default: return 0;
        endcase
    endfunction

    task automatic model_clear();
        for (int i = 0; i < N; i++) m_busy[i] = 1'b0;
        m_out = '0;
    endtask

    task automatic model_edge();
        int d;
        int fi;
        int r;
        CDB nout;
        d  = -1;
        fi = -1;
        for (int i = N - 1; i >= 0; i--) begin
            if (m_busy[i] && m_rj[i] && m_rk[i]) d = i;
            if (!m_busy[i]) fi = i;
        end
        nout = m_out;
        if (d >= 0 && (!m_out.valid || flush)) begin
            r = model_alu(m_op[d], int'(m_vj[d]), int'(m_vk[d]));
            nout = {1'b1, m_dest[d], lc3b_word'(r)};
        end else begin
            d = -1;
            if (flush) nout = '0;
        end
        for (int i = 0; i < N; i++) begin
            if (m_busy[i] && CDB_in.valid) begin
                if (!m_rj[i] && m_qj[i] == CDB_in.tag) begin m_vj[i] = CDB_in.data; m_rj[i] = 1'b1; end
                if (!m_rk[i] && m_qk[i] == CDB_in.tag) begin m_vk[i] = CDB_in.data; m_rk[i] = 1'b1; end
            end
        end
        if (d >= 0) m_busy[d] = 1'b0;
        if (issue_valid && fi >= 0) begin
            m_busy[fi] = 1'b1;
            m_op[fi]   = int'(issue_op);
            m_dest[fi] = issue_dest;
            m_vj[fi]   = issue_Vj;
            m_vk[fi]   = issue_Vk;
            m_qj[fi]   = issue_Qj;
            m_qk[fi]   = issue_Qk;
            m_rj[fi]   = issue_rdy_j;
            m_rk[fi]   = issue_rdy_k;
            if (!issue_rdy_j && CDB_in.valid && CDB_in.tag == issue_Qj) begin m_vj[fi] = CDB_in.data; m_rj[fi] = 1'b1; end
            if (!issue_rdy_k && CDB_in.valid && CDB_in.tag == issue_Qk) begin m_vk[fi] = CDB_in.data; m_rk[fi] = 1'b1; end
        end
        m_out = nout;
    endtask

    initial begin
        model_clear();
        forever begin
            @(posedge clk or posedge reset);
            if (reset) model_clear();
            else       model_edge();
        end
    end

    function automatic bit model_full();
        int c;
        c = 0;
        for (int i = 0; i < N; i++) if (m_busy[i]) c++;
        return (c == N);
    endfunction

    // Per-cycle comparison, away from the active edge.
    always @(negedge clk) begin
        n_cmp++;
        if (RS_CDB_out !== m_out) begin
            n_bad++;
            $display("FAIL model_out t=%0t: got v=%b tag=%0d data=%h, want v=%b tag=%0d data=%h",
                     $time, RS_CDB_out.valid, RS_CDB_out.tag, RS_CDB_out.data,
                     m_out.valid, m_out.tag, m_out.data);
        end
        n_cmp++;
        if (full !== model_full()) begin
            n_bad++;
            $display("FAIL model_full t=%0t: got %b want %b", $time, full, model_full());
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string nm, input logic v, input rob_tag t, input lc3b_word d);
        CDB e;
        e = {v, t, d};
        n_cmp++;
        if (RS_CDB_out !== e) begin
            n_bad++;
            $display("FAIL %s: got v=%b tag=%0d data=%h, want v=%b tag=%0d data=%h",
                     nm, RS_CDB_out.valid, RS_CDB_out.tag, RS_CDB_out.data, v, t, d);
        end
    endtask

    task automatic chk_full(input string nm, input logic f);
        n_cmp++;
        if (full !== f) begin
            n_bad++;
            $display("FAIL %s: got full=%b want %b", nm, full, f);
        end
    endtask

    task automatic iss(input lc3b_aluop op, input rob_tag d, input lc3b_word vj, input lc3b_word vk,
                       input rob_tag qj, input rob_tag qk, input logic rj, input logic rk);
        issue_valid = 1'b1;
        issue_op    = op;
        issue_dest  = d;
        issue_Vj    = vj;
        issue_Vk    = vk;
        issue_Qj    = qj;
        issue_Qk    = qk;
        issue_rdy_j = rj;
        issue_rdy_k = rk;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        lc3b_aluop undef_op;
        logic [2:0] raw7;
        raw7 = 3'd7;
        undef_op = lc3b_aluop'(raw7);

        // Reset state
        repeat (2) step();
        chk_out("reset_out", 1'b0, 3'd0, 16'h0000);
        chk_full("reset_full", 1'b0);
        reset = 1'b0;
        step();

        // Ready ADD, result exactly two cycles after issue, then cleared by flush
        flush = 1'b1;
        iss(alu_add, 3'd5, 16'h7FFF, 16'h0001, 3'd0, 3'd0, 1'b1, 1'b1);
        step();
        issue_valid = 1'b0;
        chk_out("add_n1", 1'b0, 3'd0, 16'h0000);
        step();
        chk_out("add_n2", 1'b1, 3'd5, 16'h8000);
        step();
        chk_out("add_n3", 1'b0, 3'd0, 16'h0000);

        // Operand wait on tag 3; tag 2 must not be captured
        iss(alu_and, 3'd1, 16'h0FFF, 16'h0000, 3'd0, 3'd3, 1'b1, 1'b0);
        step();
        issue_valid = 1'b0;
        repeat (3) step();
        chk_out("wait_idle", 1'b0, 3'd0, 16'h0000);
        CDB_in = {1'b1, 3'd2, 16'hFFFF};
        step();
        CDB_in = '0;
        repeat (2) step();
        chk_out("wrong_tag", 1'b0, 3'd0, 16'h0000);
        CDB_in = {1'b1, 3'd3, 16'h00F0};
        step();
        CDB_in = '0;
        chk_out("snoop_m1", 1'b0, 3'd0, 16'h0000);
        step();
        chk_out("snoop_m2", 1'b1, 3'd1, 16'h00F0);
        step();

        // Issue-cycle bypass
        iss(alu_pass, 3'd2, 16'h0000, 16'h0000, 3'd4, 3'd0, 1'b0, 1'b1);
        CDB_in = {1'b1, 3'd4, 16'h1234};
        step();
        issue_valid = 1'b0;
        CDB_in = '0;
        step();
        chk_out("bypass", 1'b1, 3'd2, 16'h1234);
        step();

        // Shifts and an undefined opcode, back to back
        iss(alu_sra, 3'd3, 16'h8000, 16'h0004, 3'd0, 3'd0, 1'b1, 1'b1);
        step();
        iss(alu_srl, 3'd4, 16'h8000, 16'h0004, 3'd0, 3'd0, 1'b1, 1'b1);
        step();
        chk_out("sra", 1'b1, 3'd3, 16'hF800);
        iss(alu_sll, 3'd6, 16'h0001, 16'h000F, 3'd0, 3'd0, 1'b1, 1'b1);
        step();
        chk_out("srl", 1'b1, 3'd4, 16'h0800);
        iss(undef_op, 3'd7, 16'hFFFF, 16'hFFFF, 3'd0, 3'd0, 1'b1, 1'b1);
        step();
        issue_valid = 1'b0;
        chk_out("sll", 1'b1, 3'd6, 16'h8000);
        step();
        chk_out("undef_op", 1'b1, 3'd7, 16'h0000);
        step();
        chk_out("shift_drain", 1'b0, 3'd0, 16'h0000);

        // Backpressure: buffer holds A, three more ops fill every slot
        flush = 1'b0;
        iss(alu_add, 3'd5, 16'h0010, 16'h0001, 3'd0, 3'd0, 1'b1, 1'b1);
        step();
        issue_valid = 1'b0;
        step();
        chk_out("bp_a_loaded", 1'b1, 3'd5, 16'h0011);
        iss(alu_and, 3'd1, 16'hFF00, 16'h0F0F, 3'd0, 3'd0, 1'b1, 1'b1);
        step();
        iss(alu_not, 3'd2, 16'h00FF, 16'h0000, 3'd0, 3'd0, 1'b1, 1'b1);
        step();
        iss(alu_add, 3'd3, 16'hFFFF, 16'h0002, 3'd0, 3'd0, 1'b1, 1'b1);
        step();
        issue_valid = 1'b0;
        chk_full("bp_full", 1'b1);
        chk_out("bp_hold1", 1'b1, 3'd5, 16'h0011);
        repeat (2) step();
        chk_full("bp_full_hold", 1'b1);
        chk_out("bp_hold2", 1'b1, 3'd5, 16'h0011);
        flush = 1'b1;
        step();
        chk_out("bp_slot0", 1'b1, 3'd1, 16'h0F00);
        chk_full("bp_unfull", 1'b0);
        step();
        chk_out("bp_slot1", 1'b1, 3'd2, 16'hFF00);
        step();
        chk_out("bp_slot2", 1'b1, 3'd3, 16'h0001);
        step();
        chk_out("bp_drained", 1'b0, 3'd0, 16'h0000);

        // Reset in the middle of operation
        flush = 1'b0;
        iss(alu_add, 3'd1, 16'h0001, 16'h0001, 3'd0, 3'd0, 1'b1, 1'b1);
        step();
        iss(alu_add, 3'd2, 16'h0002, 16'h0002, 3'd0, 3'd0, 1'b1, 1'b1);
        reset = 1'b1;
        #1;
        chk_out("midreset_out", 1'b0, 3'd0, 16'h0000);
        chk_full("midreset_full", 1'b0);
        step();
        reset = 1'b0;
        issue_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            chk_out("post_reset", 1'b0, 3'd0, 16'h0000);
        end
        chk_full("post_reset_full", 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
